// File: rtl/sha_mem_responder_pkg.sv
// rtl/sha_mem_responder_pkg.sv - shared types and constants for the SHA memory responder
package sha_mem_pkg;

  localparam int WORD_W = 32;
  localparam int ADDR_W = 16;

  localparam logic [ADDR_W-1:0] MSG_BASE = 16'h0000;
  localparam logic [ADDR_W-1:0] OUT_BASE = 16'h0020;

  typedef enum logic [2:0] {
    HOST     = 3'd0,
    START    = 3'd1,
    WAIT_LOW = 3'd2,
    RUN      = 3'd3,
    FIN      = 3'd4
  } state_t;

  // True when a word address lies inside a storage array of 'depth' words.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr, input int depth);
    return int'(addr) < depth;
  endfunction

endpackage

// File: rtl/sha_mem_responder_if.sv
// rtl/sha_mem_responder_if.sv - hasher memory bus and host access port bundle
interface sha_mem_responder_if;
  import sha_mem_pkg::*;

  // Hasher side
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [WORD_W-1:0] mem_write_data;
  logic [WORD_W-1:0] mem_read_data;

  // Host side
  logic              host_valid;
  logic              host_ready;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [WORD_W-1:0] host_wdata;
  logic              host_rvalid;
  logic [WORD_W-1:0] host_rdata;

  modport slave (
    input  mem_addr, mem_we, mem_write_data,
    input  host_valid, host_we, host_addr, host_wdata,
    output mem_read_data, host_ready, host_rvalid, host_rdata
  );

  modport master (
    output mem_addr, mem_we, mem_write_data,
    output host_valid, host_we, host_addr, host_wdata,
    input  mem_read_data, host_ready, host_rvalid, host_rdata
  );

endinterface

// File: rtl/sha_mem_responder_ram.sv
// rtl/sha_mem_responder_ram.sv - word storage with one write port and two registered read ports
module sha_mem_ram
  import sha_mem_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  output logic              wr_in_range,
  input  logic [ADDR_W-1:0] rd_a_addr,
  output logic [WORD_W-1:0] rd_a_data,
  output logic              rd_a_in_range,
  input  logic              rd_b_en,
  input  logic [ADDR_W-1:0] rd_b_addr,
  output logic [WORD_W-1:0] rd_b_data,
  output logic              rd_b_in_range
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WORD_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_a_idx;
  logic [IDX_W-1:0] rd_b_idx;

  assign wr_in_range   = addr_in_range(wr_addr, DEPTH);
  assign rd_a_in_range = addr_in_range(rd_a_addr, DEPTH);
  assign rd_b_in_range = addr_in_range(rd_b_addr, DEPTH);

  assign wr_idx   = wr_addr[IDX_W-1:0];
  assign rd_a_idx = rd_a_addr[IDX_W-1:0];
  assign rd_b_idx = rd_b_addr[IDX_W-1:0];

  // Storage write; contents deliberately survive reset, out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (wr_en && wr_in_range) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Hasher read port: samples every cycle, so a same-cycle write returns the old word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_a_data <= '0;
    end else begin
      rd_a_data <= rd_a_in_range ? mem[rd_a_idx] : '0;
    end
  end

  // Host read port: only updates on a host read so the last result is held.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_b_data <= '0;
    end else if (rd_b_en) begin
      rd_b_data <= rd_b_in_range ? mem[rd_b_idx] : '0;
    end
  end

endmodule

// File: rtl/sha_mem_responder.sv
// rtl/sha_mem_responder.sv - memory responder and run sequencer for the SHA-256 hasher
module sha_mem_responder
  import sha_mem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                clk,
  input  logic                reset_n,
  sha_mem_responder_if.slave  bus,
  output logic                start,
  input  logic                done,
  input  logic                run,
  output logic                busy,
  output logic                finished,
  output logic                timeout,
  output logic                addr_err,
  output logic [15:0]         wr_count
);

  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  state_t state_q;
  state_t state_d;

  logic            ready_q;
  logic            host_ready_c;
  logic [WD_W-1:0] wdog_q;
  logic            wdog_hit;
  logic            wdog_abort;
  logic            run_accept;
  logic            hasher_active;
  logic            hasher_wr;
  logic            host_xfer;
  logic            host_wr;
  logic            host_rd;
  logic            err_evt;
  logic            host_rvalid_q;

  logic              ram_wr_en;
  logic [ADDR_W-1:0] ram_wr_addr;
  logic [WORD_W-1:0] ram_wr_data;
  logic              ram_wr_in_range;
  logic [WORD_W-1:0] ram_rd_a_data;
  logic              ram_rd_a_in_range;
  logic [WORD_W-1:0] ram_rd_b_data;
  logic              ram_rd_b_in_range;

  assign wdog_hit      = (wdog_q >= WD_W'(TIMEOUT_CYC - 1));
  assign run_accept    = (state_q == HOST) && run;
  assign hasher_active = (state_q == WAIT_LOW) || (state_q == RUN);
  assign hasher_wr     = hasher_active && bus.mem_we;
  assign host_xfer     = bus.host_valid && host_ready_c;
  assign host_wr       = host_xfer && bus.host_we;
  assign host_rd       = host_xfer && !bus.host_we;

  // The hasher bus only counts as live during a run; host errors count on any transfer.
  assign err_evt = (host_xfer && !ram_rd_b_in_range) ||
                   (hasher_active && !ram_rd_a_in_range);

  // Host and hasher writes never overlap: the host port is only open in HOST.
  assign ram_wr_en   = hasher_wr || host_wr;
  assign ram_wr_addr = host_wr ? bus.host_addr  : bus.mem_addr;
  assign ram_wr_data = host_wr ? bus.host_wdata : bus.mem_write_data;

  sha_mem_ram #(.DEPTH(DEPTH)) u_ram (
    .clk           (clk),
    .reset_n       (reset_n),
    .wr_en         (ram_wr_en),
    .wr_addr       (ram_wr_addr),
    .wr_data       (ram_wr_data),
    .wr_in_range   (ram_wr_in_range),
    .rd_a_addr     (bus.mem_addr),
    .rd_a_data     (ram_rd_a_data),
    .rd_a_in_range (ram_rd_a_in_range),
    .rd_b_en       (host_rd),
    .rd_b_addr     (bus.host_addr),
    .rd_b_data     (ram_rd_b_data),
    .rd_b_in_range (ram_rd_b_in_range)
  );

  assign bus.mem_read_data = ram_rd_a_data;
  assign bus.host_rdata    = ram_rd_b_data;
  assign bus.host_rvalid   = host_rvalid_q;
  assign bus.host_ready    = host_ready_c;

  // State register; ready_q keeps the host port closed while reset is held.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= HOST;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= 1'b1;
    end
  end

  // Sequencer next state and decoded outputs.
  always_comb begin
    state_d      = state_q;
    start        = 1'b0;
    busy         = 1'b0;
    finished     = 1'b0;
    host_ready_c = 1'b0;
    wdog_abort   = 1'b0;
    case (state_q)
      HOST: begin
        host_ready_c = ready_q;
        if (run) state_d = START;
      end
      START: begin
        start   = 1'b1;
        busy    = 1'b1;
        state_d = WAIT_LOW;
      end
      WAIT_LOW: begin
        busy = 1'b1;
        if (!done) begin
          state_d = RUN;
        end else if (wdog_hit) begin
          state_d    = FIN;
          wdog_abort = 1'b1;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (done) begin
          state_d = FIN;
        end else if (wdog_hit) begin
          state_d    = FIN;
          wdog_abort = 1'b1;
        end
      end
      FIN: begin
        busy     = 1'b1;
        finished = 1'b1;
        state_d  = HOST;
      end
      default: state_d = HOST;
    endcase
  end

  // Watchdog counts cycles spent waiting on the hasher and saturates at its limit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog_q <= '0;
    end else if (run_accept) begin
      wdog_q <= '0;
    end else if (hasher_active && (wdog_q != WD_W'(TIMEOUT_CYC))) begin
      wdog_q <= wdog_q + WD_W'(1);
    end
  end

  // Sticky status flags; a fresh error in the accept cycle wins over the clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timeout  <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      if (run_accept)      timeout <= 1'b0;
      else if (wdog_abort) timeout <= 1'b1;
      if (err_evt)         addr_err <= 1'b1;
      else if (run_accept) addr_err <= 1'b0;
    end
  end

  // Count of accepted in-range hasher writes for the current run, saturating.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_count <= '0;
    end else if (run_accept) begin
      wr_count <= '0;
    end else if (hasher_wr && ram_wr_in_range && (wr_count != 16'hFFFF)) begin
      wr_count <= wr_count + 16'd1;
    end
  end

  // Host read data valid follows the accepted read by one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      host_rvalid_q <= 1'b0;
    end else begin
      host_rvalid_q <= host_rd;
    end
  end

endmodule

// File: tb/tb_sha_mem_responder.sv
// tb/tb_sha_mem_responder.sv - self-checking bench for sha_mem_responder
module tb_sha_mem_responder;
  import sha_mem_pkg::*;

  localparam int DEPTH      = 256;
  localparam int TB_TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        done;
  logic        run;
  logic        busy;
  logic        finished;
  logic        timeout;
  logic        addr_err;
  logic [15:0] wr_count;

  always #5 clk = ~clk;

  sha_mem_responder_if bus();

  sha_mem_responder #(.DEPTH(DEPTH), .TIMEOUT_CYC(TB_TIMEOUT)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .start    (start),
    .done     (done),
    .run      (run),
    .busy     (busy),
    .finished (finished),
    .timeout  (timeout),
    .addr_err (addr_err),
    .wr_count (wr_count)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] ref_mem   [DEPTH];
  bit          ref_known [DEPTH];
  bit          exp_addr_err;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [15:0] a, input logic [31:0] d);
    bus.host_valid = 1'b1;
    bus.host_we    = 1'b1;
    bus.host_addr  = a;
    bus.host_wdata = d;
    tick();
    bus.host_valid = 1'b0;
    bus.host_we    = 1'b0;
    if (int'(a) < DEPTH) begin
      ref_mem[a]   = d;
      ref_known[a] = 1'b1;
    end else begin
      exp_addr_err = 1'b1;
    end
  endtask

  task automatic host_read(input logic [15:0] a, output logic [31:0] d, output logic rv);
    bus.host_valid = 1'b1;
    bus.host_we    = 1'b0;
    bus.host_addr  = a;
    tick();
    bus.host_valid = 1'b0;
    rv = bus.host_rvalid;
    d  = bus.host_rdata;
    if (int'(a) >= DEPTH) exp_addr_err = 1'b1;
  endtask

  task automatic start_run();
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  task automatic wait_finished(output int n, output bit ok, output bit busy_drop);
    n = 0;
    ok = 1'b0;
    busy_drop = 1'b0;
    for (int i = 0; i < TB_TIMEOUT + 8; i++) begin
      tick();
      n++;
      if (finished) begin
        ok = 1'b1;
        break;
      end
      if (!busy) busy_drop = 1'b1;
    end
  endtask

  task automatic quick_run();
    int  n;
    bit  ok;
    bit  drop;
    start_run();
    tick();
    done = 1'b0;
    tick();
    done = 1'b1;
    wait_finished(n, ok, drop);
    tick();
    exp_addr_err = 1'b0;
  endtask

  // Golden digest rule implemented by the bench's stand-in hasher.
  function automatic logic [31:0] dig(input logic [31:0] a, input logic [31:0] b, input int i);
    return ({a[15:0], a[31:16]} ^ b) + 32'(i);
  endfunction

  task automatic test_reset();
    reset_n            = 1'b0;
    done               = 1'b1;
    run                = 1'b0;
    bus.mem_addr       = '0;
    bus.mem_we         = 1'b0;
    bus.mem_write_data = '0;
    bus.host_valid     = 1'b0;
    bus.host_we        = 1'b0;
    bus.host_addr      = '0;
    bus.host_wdata     = '0;
    exp_addr_err       = 1'b0;
    repeat (3) tick();
    checks++;
    if ({start, busy, finished, timeout, addr_err} !== 5'b0)
      begin errors++; $display("FAIL reset_flags: got %b expected 00000", {start, busy, finished, timeout, addr_err}); end
    checks++;
    if (wr_count !== 16'h0) begin errors++; $display("FAIL reset_wr_count: got %h expected 0000", wr_count); end
    checks++;
    if ({bus.host_ready, bus.host_rvalid} !== 2'b00)
      begin errors++; $display("FAIL reset_host: got %b expected 00", {bus.host_ready, bus.host_rvalid}); end
    checks++;
    if ({bus.host_rdata, bus.mem_read_data} !== 64'h0)
      begin errors++; $display("FAIL reset_data: got %h expected 0", {bus.host_rdata, bus.mem_read_data}); end
    reset_n = 1'b1;
    repeat (2) tick();
    checks++;
    if (bus.host_ready !== 1'b1 || busy !== 1'b0)
      begin errors++; $display("FAIL idle_after_reset: got ready=%b busy=%b expected ready=1 busy=0", bus.host_ready, busy); end
  endtask

  task automatic test_host_rw();
    logic [31:0] d;
    logic        rv;
    host_write(16'd5, 32'hA5A5_0001);
    checks++;
    if (bus.host_rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_on_write: got %b expected 0", bus.host_rvalid); end
    host_read(16'd5, d, rv);
    checks++;
    if (rv !== 1'b1) begin errors++; $display("FAIL host_rvalid: got %b expected 1", rv); end
    checks++;
    if (d !== 32'hA5A5_0001) begin errors++; $display("FAIL host_rdata: got %h expected a5a50001", d); end
    tick();
    checks++;
    if (bus.host_rvalid !== 1'b0 || bus.host_rdata !== 32'hA5A5_0001)
      begin errors++; $display("FAIL host_rdata_hold: got rv=%b d=%h expected rv=0 d=a5a50001", bus.host_rvalid, bus.host_rdata); end
  endtask

  task automatic test_hasher_read();
    bus.mem_addr = 16'd5;
    tick();
    checks++;
    if (bus.mem_read_data !== 32'hA5A5_0001)
      begin errors++; $display("FAIL mem_read: got %h expected a5a50001", bus.mem_read_data); end
    bus.mem_we         = 1'b1;
    bus.mem_write_data = 32'hDEAD_BEEF;
    tick();
    bus.mem_we = 1'b0;
    tick();
    checks++;
    if (bus.mem_read_data !== 32'hA5A5_0001)
      begin errors++; $display("FAIL host_state_write_ignored: got %h expected a5a50001", bus.mem_read_data); end
    bus.mem_addr = 16'd300;
    tick();
    checks++;
    if (bus.mem_read_data !== 32'h0) begin errors++; $display("FAIL mem_read_oor: got %h expected 0", bus.mem_read_data); end
    bus.mem_addr = 16'd0;
  endtask

  task automatic test_full_run();
    logic [31:0] msg_rd [16];
    logic [31:0] d;
    logic        rv;
    int          n;
    bit          ok;
    bit          drop;
    bit          early_drop;
    for (int i = 0; i < 20; i++) host_write(MSG_BASE + 16'(i), $urandom);
    for (int i = 0; i < 8; i++) begin
      ref_mem[OUT_BASE + 16'(i)]   = dig(ref_mem[i], ref_mem[i + 8], i);
      ref_known[OUT_BASE + 16'(i)] = 1'b1;
    end
    start_run();
    checks++;
    if ({start, busy, bus.host_ready} !== 3'b110)
      begin errors++; $display("FAIL start_cycle: got start/busy/ready=%b expected 110", {start, busy, bus.host_ready}); end
    tick();
    checks++;
    if ({start, busy} !== 2'b01) begin errors++; $display("FAIL start_one_cycle: got start/busy=%b expected 01", {start, busy}); end
    done = 1'b0;
    tick();
    early_drop = 1'b0;
    for (int j = 0; j < 16; j++) begin
      bus.mem_addr = MSG_BASE + 16'(j);
      tick();
      msg_rd[j] = bus.mem_read_data;
      if (!busy) early_drop = 1'b1;
    end
    for (int i = 0; i < 8; i++) begin
      bus.mem_we         = 1'b1;
      bus.mem_addr       = OUT_BASE + 16'(i);
      bus.mem_write_data = dig(msg_rd[i], msg_rd[i + 8], i);
      tick();
      if (!busy) early_drop = 1'b1;
    end
    bus.mem_we   = 1'b0;
    bus.mem_addr = '0;
    done = 1'b1;
    wait_finished(n, ok, drop);
    checks++;
    if (!ok || drop || early_drop)
      begin errors++; $display("FAIL run_busy_finish: got finished=%0d busy_drop=%0d expected finished=1 busy_drop=0", ok, drop | early_drop); end
    checks++;
    if (wr_count !== 16'd8 || timeout !== 1'b0)
      begin errors++; $display("FAIL run_wr_count: got wr=%0d to=%b expected wr=8 to=0", wr_count, timeout); end
    tick();
    checks++;
    if (busy !== 1'b0 || bus.host_ready !== 1'b1)
      begin errors++; $display("FAIL run_return_host: got busy=%b ready=%b expected busy=0 ready=1", busy, bus.host_ready); end
    for (int i = 0; i < 8; i++) begin
      host_read(OUT_BASE + 16'(i), d, rv);
      checks++;
      if (rv !== 1'b1 || d !== ref_mem[OUT_BASE + 16'(i)])
        begin errors++; $display("FAIL digest[%0d]: got %h expected %h", i, d, ref_mem[OUT_BASE + 16'(i)]); end
    end
  endtask

  task automatic test_same_cycle();
    int n;
    bit ok;
    bit drop;
    host_write(16'd5, 32'hA5A5_0001);
    start_run();
    tick();
    done = 1'b0;
    tick();
    bus.mem_addr       = 16'd5;
    bus.mem_we         = 1'b1;
    bus.mem_write_data = 32'h0000_1234;
    tick();
    bus.mem_we = 1'b0;
    checks++;
    if (bus.mem_read_data !== 32'hA5A5_0001)
      begin errors++; $display("FAIL same_cycle_old: got %h expected a5a50001", bus.mem_read_data); end
    tick();
    ref_mem[5] = 32'h0000_1234;
    checks++;
    if (bus.mem_read_data !== 32'h0000_1234)
      begin errors++; $display("FAIL same_cycle_new: got %h expected 00001234", bus.mem_read_data); end
    run = 1'b1;
    tick();
    run = 1'b0;
    checks++;
    if (busy !== 1'b1 || wr_count !== 16'd1)
      begin errors++; $display("FAIL run_ignored_busy: got busy=%b wr=%0d expected busy=1 wr=1", busy, wr_count); end
    bus.mem_addr = '0;
    done = 1'b1;
    wait_finished(n, ok, drop);
    tick();
  endtask

  task automatic test_timeout();
    int n;
    bit ok;
    bit drop;
    start_run();
    wait_finished(n, ok, drop);
    checks++;
    if (!ok || n < TB_TIMEOUT || n > TB_TIMEOUT + 2)
      begin errors++; $display("FAIL timeout_latency: got ok=%0d cycles=%0d expected %0d..%0d", ok, n, TB_TIMEOUT, TB_TIMEOUT + 2); end
    checks++;
    if (timeout !== 1'b1 || wr_count !== 16'd0)
      begin errors++; $display("FAIL timeout_flag: got to=%b wr=%0d expected to=1 wr=0", timeout, wr_count); end
    tick();
    tick();
    checks++;
    if (timeout !== 1'b1 || busy !== 1'b0)
      begin errors++; $display("FAIL timeout_sticky: got to=%b busy=%b expected to=1 busy=0", timeout, busy); end
    start_run();
    checks++;
    if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b expected 0", timeout); end
    tick();
    done = 1'b0;
    tick();
    done = 1'b1;
    wait_finished(n, ok, drop);
    checks++;
    if (!ok || timeout !== 1'b0)
      begin errors++; $display("FAIL normal_after_timeout: got ok=%0d to=%b expected ok=1 to=0", ok, timeout); end
    tick();
  endtask

  task automatic test_addr_err();
    logic [31:0] d;
    logic        rv;
    int          n;
    bit          ok;
    bit          drop;
    checks++;
    if (addr_err !== exp_addr_err) begin errors++; $display("FAIL addr_err_initial: got %b expected %b", addr_err, exp_addr_err); end
    host_write(16'd44, $urandom);
    host_write(16'd300, 32'hBAD0_0BAD);
    checks++;
    if (addr_err !== 1'b1) begin errors++; $display("FAIL addr_err_write: got %b expected 1", addr_err); end
    host_read(16'd44, d, rv);
    checks++;
    if (d !== ref_mem[44]) begin errors++; $display("FAIL oor_write_alias: got %h expected %h", d, ref_mem[44]); end
    host_read(16'd300, d, rv);
    checks++;
    if (rv !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL oor_read: got rv=%b d=%h expected rv=1 d=0", rv, d); end
    start_run();
    checks++;
    if (addr_err !== 1'b0) begin errors++; $display("FAIL addr_err_clear: got %b expected 0", addr_err); end
    tick();
    done = 1'b0;
    tick();
    bus.mem_addr = 16'd400;
    tick();
    checks++;
    if (bus.mem_read_data !== 32'h0 || addr_err !== 1'b1)
      begin errors++; $display("FAIL hasher_oor: got d=%h err=%b expected d=0 err=1", bus.mem_read_data, addr_err); end
    bus.mem_addr = '0;
    done = 1'b1;
    wait_finished(n, ok, drop);
    tick();
    exp_addr_err = 1'b1;
    checks++;
    if (addr_err !== 1'b1) begin errors++; $display("FAIL addr_err_sticky: got %b expected 1", addr_err); end
  endtask

  task automatic test_random_host();
    logic [15:0] a;
    logic [31:0] d;
    logic        rv;
    bit          we;
    logic [31:0] exp_d;
    quick_run();
    for (int it = 0; it < 40; it++) begin
      a  = 16'($urandom_range(0, 299));
      we = 1'($urandom_range(0, 1));
      if (int'(a) < DEPTH && !ref_known[a]) we = 1'b1;
      if (we) begin
        host_write(a, $urandom);
      end else begin
        exp_d = (int'(a) < DEPTH) ? ref_mem[a] : 32'h0;
        host_read(a, d, rv);
        checks++;
        if (rv !== 1'b1 || d !== exp_d)
          begin errors++; $display("FAIL random_read@%0d: got rv=%b d=%h expected rv=1 d=%h", a, rv, d, exp_d); end
      end
    end
    checks++;
    if (addr_err !== exp_addr_err) begin errors++; $display("FAIL random_addr_err: got %b expected %b", addr_err, exp_addr_err); end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] d;
    logic        rv;
    start_run();
    tick();
    done = 1'b0;
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    checks++;
    if ({start, busy, finished} !== 3'b000)
      begin errors++; $display("FAIL async_reset_drop: got start/busy/fin=%b expected 000", {start, busy, finished}); end
    tick();
    tick();
    reset_n = 1'b1;
    done    = 1'b1;
    exp_addr_err = 1'b0;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || bus.host_ready !== 1'b1 || wr_count !== 16'd0)
      begin errors++; $display("FAIL post_reset_host: got busy=%b ready=%b wr=%0d expected 0 1 0", busy, bus.host_ready, wr_count); end
    for (int i = 0; i < 48; i++) begin
      if (ref_known[i]) begin
        host_read(16'(i), d, rv);
        checks++;
        if (d !== ref_mem[i]) begin errors++; $display("FAIL ram_kept@%0d: got %h expected %h", i, d, ref_mem[i]); end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: got no finish expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_host_rw();
    test_hasher_read();
    test_full_run();
    test_same_cycle();
    test_timeout();
    test_addr_err();
    test_random_host();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
